// File: rtl/mbldcm_commutation_sequencer_pkg.sv
// Shared constants and helpers for the mBldcm commutation sequencer:
// fault bit indices, mode encodings, the hall-to-phase map and mod-6 phase arithmetic.
package mbldcm_commutation_sequencer_pkg;

  localparam int kPhaseCount = 6;

  localparam int kFaultInvalid = 0;
  localparam int kFaultSkip    = 1;
  localparam int kFaultStall   = 2;

  typedef enum logic {
    kModeOpenLoop = 1'b0,
    kModeHall     = 1'b1
  } tMode;

  // Hall code {W,V,U} that corresponds to each electrical phase.
  localparam logic [2:0] kHallPhase0 = 3'd1;
  localparam logic [2:0] kHallPhase1 = 3'd3;
  localparam logic [2:0] kHallPhase2 = 3'd2;
  localparam logic [2:0] kHallPhase3 = 3'd6;
  localparam logic [2:0] kHallPhase4 = 3'd4;
  localparam logic [2:0] kHallPhase5 = 3'd5;

  typedef struct packed {
    logic       valid;
    logic [2:0] phase;
  } tHallDecode;

  function automatic tHallDecode hallToPhase(input logic [2:0] code);
    tHallDecode d;
    d.valid = 1'b1;
    d.phase = 3'd0;
    case (code)
      kHallPhase0: d.phase = 3'd0;
      kHallPhase1: d.phase = 3'd1;
      kHallPhase2: d.phase = 3'd2;
      kHallPhase3: d.phase = 3'd3;
      kHallPhase4: d.phase = 3'd4;
      kHallPhase5: d.phase = 3'd5;
      default:     d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] phaseInc(input logic [2:0] a);
    return (a == 3'(kPhaseCount - 1)) ? 3'd0 : a + 3'd1;
  endfunction

  function automatic logic [2:0] phaseDec(input logic [2:0] a);
    return (a == 3'd0) ? 3'(kPhaseCount - 1) : a - 3'd1;
  endfunction

  // Both operands must already be in 0..5.
  function automatic logic [2:0] phaseAdd(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'(kPhaseCount)) s = s - 4'(kPhaseCount);
    return s[2:0];
  endfunction

endpackage

// File: rtl/mbldcm_hall_filter.sv
// Two-flop synchroniser plus depth filter for the raw hall inputs. oAccept is a
// one-cycle strobe raised in the cycle before the accepted-code register loads oCode.
module mbldcm_hall_filter #(
  parameter int pHallFilterDepth = 4
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iClear,
  input  logic [2:0] iHall,
  output logic [2:0] oCode,
  output logic       oAccept
);

  localparam logic [3:0] kDepth = 4'(pHallFilterDepth);

  logic [2:0] sync1, sync2;
  logic [2:0] candidate, candidateNext;
  logic [2:0] accepted;
  logic [3:0] count, countNext;

  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    candidateNext = candidate;
    countNext     = count;
    if (sync2 != candidate) begin
      candidateNext = sync2;
      countNext     = 4'd1;
    end else if (count != kDepth) begin
      countNext = count + 4'd1;
    end
    oCode   = candidateNext;
    oAccept = !iClear && (countNext == kDepth) && (candidateNext != accepted);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      sync1     <= '0;
      sync2     <= '0;
      candidate <= '0;
      count     <= '0;
      accepted  <= '0;
    end else begin
      sync1     <= iHall;
      sync2     <= sync1;
      candidate <= candidateNext;
      // Clearing the accepted code lets the current hall code be re-accepted after a mode switch.
      if (iClear) begin
        count    <= '0;
        accepted <= '0;
      end else begin
        count <= countNext;
        if (oAccept) accepted <= candidateNext;
      end
    end
  end

endmodule

// File: rtl/mbldcm_commutation_sequencer.sv
// mBldcm phase source: open-loop divider stepping or closed-loop hall commutation,
// with position/period measurement and sticky stall/skip/invalid faults.
module mbldcm_commutation_sequencer
  import mbldcm_commutation_sequencer_pkg::*;
#(
  parameter int pDivWidth        = 32,
  parameter int pHallFilterDepth = 4,
  parameter int pPeriodWidth     = 24,
  parameter int pPosWidth        = 16
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic                        iEnable,
  input  logic                        iMode,
  input  logic                        iDir,
  input  logic                        iStop,
  input  logic [pDivWidth-1:0]        iDiv,
  input  logic [2:0]                  iHall,
  input  logic [2:0]                  iHallOffset,
  input  logic [pPeriodWidth-1:0]     iStallLimit,
  input  logic                        iFaultClear,
  output logic [2:0]                  oPhase,
  output logic                        oDriveEnable,
  output logic signed [pPosWidth-1:0] oPosition,
  output logic [pPeriodWidth-1:0]     oPeriod,
  output logic [2:0]                  oFault
);

  tMode                    mode;
  logic                    modeQ;
  logic                    modeChange;
  logic                    hallActive;
  logic [2:0]              filtCode;
  logic                    filtAccept;
  tHallDecode              decoded;
  logic                    hallEvent;
  logic                    validChange;
  logic                    stepFwd;
  logic                    stepBack;
  logic [2:0]              hallPhase;
  logic                    hallLoaded;
  logic [2:0]              effOffset;
  logic [2:0]              hallOut;
  logic [2:0]              phaseQ;
  logic [2:0]              phaseNext;
  logic [pDivWidth-1:0]    divCount;
  logic [pDivWidth-1:0]    divNext;
  logic [pPeriodWidth-1:0] periodCount;
  logic [pPeriodWidth-1:0] periodInc;
  logic                    stallEvent;
  logic [2:0]              faultNext;

  assign mode       = tMode'(iMode);
  assign modeChange = (iMode != modeQ);
  assign hallActive = (mode == kModeHall);

  mbldcm_hall_filter #(
    .pHallFilterDepth(pHallFilterDepth)
  ) uHallFilter (
    .iClock (iClock),
    .iReset (iReset),
    .iClear (modeChange),
    .iHall  (iHall),
    .oCode  (filtCode),
    .oAccept(filtAccept)
  );

  assign decoded     = hallToPhase(filtCode);
  assign hallEvent   = filtAccept && hallActive;
  assign validChange = hallEvent && decoded.valid;
  assign stepFwd     = (decoded.phase == phaseInc(hallPhase));
  assign stepBack    = (decoded.phase == phaseDec(hallPhase));

  assign effOffset = (iHallOffset >= 3'(kPhaseCount)) ? 3'd0 : iHallOffset;
  assign hallOut   = phaseAdd(hallPhase, effOffset);
  // Until the first hall code is accepted the last phase keeps driving the bridges.
  assign oPhase    = (hallActive && hallLoaded) ? hallOut : phaseQ;

  // periodInc is the number of cycles elapsed since the last accepted change.
  assign periodInc  = (&periodCount) ? periodCount : periodCount + pPeriodWidth'(1);
  assign stallEvent = hallActive && !modeChange && (iStallLimit != '0) &&
                      (periodInc == iStallLimit) && (periodCount != iStallLimit);

  always_comb begin
    divNext   = divCount;
    phaseNext = phaseQ;
    if (modeChange) divNext = '0;
    if (hallActive) begin
      phaseNext = oPhase;
    end else if (!modeChange && !iStop && (iDiv != '0)) begin
      if (divCount >= iDiv) begin
        divNext = '0;
      end else if (divCount == iDiv - pDivWidth'(1)) begin
        divNext   = '0;
        phaseNext = iDir ? phaseDec(phaseQ) : phaseInc(phaseQ);
      end else begin
        divNext = divCount + pDivWidth'(1);
      end
    end
  end

  always_comb begin
    faultNext = iFaultClear ? 3'b000 : oFault;
    faultNext[kFaultInvalid] = faultNext[kFaultInvalid] | (hallEvent && !decoded.valid);
    faultNext[kFaultSkip]    = faultNext[kFaultSkip] |
                               (validChange && hallLoaded && !stepFwd && !stepBack);
    faultNext[kFaultStall]   = faultNext[kFaultStall] | stallEvent;
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      modeQ        <= 1'b0;
      divCount     <= '0;
      phaseQ       <= '0;
      hallPhase    <= '0;
      hallLoaded   <= 1'b0;
      oPosition    <= '0;
      periodCount  <= '0;
      oPeriod      <= '0;
      oFault       <= '0;
      oDriveEnable <= 1'b0;
    end else begin
      modeQ        <= iMode;
      divCount     <= divNext;
      phaseQ       <= phaseNext;
      oFault       <= faultNext;
      oDriveEnable <= iEnable && !(|oFault);

      if (!hallActive)      hallLoaded <= 1'b0;
      else if (validChange) hallLoaded <= 1'b1;

      if (validChange) begin
        hallPhase <= decoded.phase;
        if (hallLoaded) begin
          oPeriod <= periodInc;
          if (stepFwd)       oPosition <= oPosition + pPosWidth'(1);
          else if (stepBack) oPosition <= oPosition - pPosWidth'(1);
        end
      end

      if (modeChange || validChange) periodCount <= '0;
      else                           periodCount <= periodInc;
    end
  end

endmodule

// File: tb/tb_mbldcm_commutation_sequencer.sv
// Self-checking bench for mbldcm_commutation_sequencer: open-loop stepping, hall
// rotation, glitch rejection, invalid/skip/stall faults and reset mid-operation.
module tb_mbldcm_commutation_sequencer;

  logic               iClock = 1'b0;
  logic               iReset;
  logic               iEnable;
  logic               iMode;
  logic               iDir;
  logic               iStop;
  logic [31:0]        iDiv;
  logic [2:0]         iHall;
  logic [2:0]         iHallOffset;
  logic [23:0]        iStallLimit;
  logic               iFaultClear;
  logic [2:0]         oPhase;
  logic               oDriveEnable;
  logic signed [15:0] oPosition;
  logic [23:0]        oPeriod;
  logic [2:0]         oFault;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic [2:0]         phase;
    logic signed [15:0] pos;
    logic [23:0]        period;
    logic [2:0]         fault;
  } tExp;

  tExp sbQ[$];

  // Reference model state
  logic [2:0]         mOut;
  logic [2:0]         mHall;
  logic               mLoaded;
  logic signed [15:0] mPos;
  logic [23:0]        mPeriod;
  logic [2:0]         mFault;
  logic [2:0]         mOffset;

  mbldcm_commutation_sequencer #(
    .pDivWidth       (32),
    .pHallFilterDepth(4),
    .pPeriodWidth    (24),
    .pPosWidth       (16)
  ) dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iEnable     (iEnable),
    .iMode       (iMode),
    .iDir        (iDir),
    .iStop       (iStop),
    .iDiv        (iDiv),
    .iHall       (iHall),
    .iHallOffset (iHallOffset),
    .iStallLimit (iStallLimit),
    .iFaultClear (iFaultClear),
    .oPhase      (oPhase),
    .oDriveEnable(oDriveEnable),
    .oPosition   (oPosition),
    .oPeriod     (oPeriod),
    .oFault      (oFault)
  );

  always #5 iClock = ~iClock;

  task automatic tick(input int n);
    repeat (n) @(negedge iClock);
  endtask

  function automatic logic [2:0] refPhase(input logic [2:0] code);
    case (code)
      3'd1: return 3'd0;
      3'd3: return 3'd1;
      3'd2: return 3'd2;
      3'd6: return 3'd3;
      3'd4: return 3'd4;
      3'd5: return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] refAdd(input logic [2:0] p, input logic [2:0] off);
    int o;
    o = (off > 3'd5) ? 0 : int'(off);
    return 3'((int'(p) + o) % 6);
  endfunction

  // Drives a hall code and pushes the outputs the model predicts once it is accepted.
  task automatic drive_hall(input logic [2:0] code, input logic [23:0] gap);
    logic [2:0] p;
    p = refPhase(code);
    if (p == 3'd7) begin
      mFault[0] = 1'b1;
    end else begin
      if (mLoaded) begin
        if (p == 3'((int'(mHall) + 1) % 6))      mPos = mPos + 16'sd1;
        else if (p == 3'((int'(mHall) + 5) % 6)) mPos = mPos - 16'sd1;
        else                                     mFault[1] = 1'b1;
        mPeriod = gap;
      end
      mLoaded = 1'b1;
      mHall   = p;
    end
    iHall = code;
    sbQ.push_back('{(mLoaded ? refAdd(mHall, mOffset) : mOut), mPos, mPeriod, mFault});
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    tick(2);
    checkCount++; if (oPhase !== 3'd0) $display("FAIL reset_phase: got %0d want 0", oPhase); else passCount++;
    checkCount++; if (oDriveEnable !== 1'b0) $display("FAIL reset_drive: got %0d want 0", oDriveEnable); else passCount++;
    checkCount++; if (oPosition !== 16'sd0) $display("FAIL reset_pos: got %0d want 0", oPosition); else passCount++;
    checkCount++; if (oPeriod !== 24'd0) $display("FAIL reset_period: got %0d want 0", oPeriod); else passCount++;
    checkCount++; if (oFault !== 3'b000) $display("FAIL reset_fault: got %b want 000", oFault); else passCount++;
    iReset = 1'b0;
    mOut = 3'd0; mPos = '0; mPeriod = '0; mFault = '0; mLoaded = 1'b0; mHall = '0;
  endtask

  task automatic test_open_loop();
    tExp e;
    logic [2:0] prev;
    iMode = 1'b0; iDiv = 32'd5; iDir = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) iDir = 1'b1;
      prev = mOut;
      mOut = iDir ? 3'((int'(mOut) + 5) % 6) : 3'((int'(mOut) + 1) % 6);
      sbQ.push_back('{mOut, 16'sd0, 24'd0, 3'b000});
      tick(4);
      checkCount++; if (oPhase !== prev) $display("FAIL ol_hold[%0d]: got %0d want %0d", i, oPhase, prev); else passCount++;
      tick(1);
      e = sbQ.pop_front();
      checkCount++; if (oPhase !== e.phase) $display("FAIL ol_step[%0d]: got %0d want %0d", i, oPhase, e.phase); else passCount++;
    end
    checkCount++; if (oDriveEnable !== 1'b1) $display("FAIL ol_drive: got %0d want 1", oDriveEnable); else passCount++;
    // Stop freezes phase and divider.
    iStop = 1'b1;
    tick(20);
    checkCount++; if (oPhase !== 3'd3) $display("FAIL ol_stop: got %0d want 3", oPhase); else passCount++;
    iStop = 1'b0;
    tick(5);
    checkCount++; if (oPhase !== 3'd2) $display("FAIL ol_resume: got %0d want 2", oPhase); else passCount++;
    // Divide-by-one steps every cycle.
    iDiv = 32'd1; iDir = 1'b0;
    tick(1);
    checkCount++; if (oPhase !== 3'd3) $display("FAIL ol_div1_a: got %0d want 3", oPhase); else passCount++;
    tick(1);
    checkCount++; if (oPhase !== 3'd4) $display("FAIL ol_div1_b: got %0d want 4", oPhase); else passCount++;
    // Lowering the divisor below the count restarts it without a step.
    iDiv = 32'd10;
    tick(7);
    iDiv = 32'd3;
    tick(3);
    checkCount++; if (oPhase !== 3'd4) $display("FAIL ol_lower_hold: got %0d want 4", oPhase); else passCount++;
    tick(1);
    checkCount++; if (oPhase !== 3'd5) $display("FAIL ol_lower_step: got %0d want 5", oPhase); else passCount++;
    iDiv = 32'd0;
    tick(10);
    checkCount++; if (oPhase !== 3'd5) $display("FAIL ol_div0: got %0d want 5", oPhase); else passCount++;
    mOut = 3'd5;
  endtask

  task automatic test_hall_rotation();
    logic [2:0] codes [7];
    tExp e;
    codes = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5, 3'd1};
    iMode = 1'b1; iHallOffset = 3'd2; mOffset = 3'd2;
    for (int i = 0; i < 7; i++) begin
      drive_hall(codes[i], 24'd50);
      tick(5);
      checkCount++; if (oPhase !== mOut) $display("FAIL rot_latency[%0d]: got %0d want %0d", i, oPhase, mOut); else passCount++;
      tick(1);
      e = sbQ.pop_front();
      checkCount++; if (oPhase !== e.phase) $display("FAIL rot_phase[%0d]: got %0d want %0d", i, oPhase, e.phase); else passCount++;
      checkCount++; if (oPosition !== e.pos) $display("FAIL rot_pos[%0d]: got %0d want %0d", i, oPosition, e.pos); else passCount++;
      checkCount++; if (oPeriod !== e.period) $display("FAIL rot_period[%0d]: got %0d want %0d", i, oPeriod, e.period); else passCount++;
      mOut = e.phase;
      tick(44);
    end
    // Offset acts without a hall edge; 6 and 7 mean zero.
    iHallOffset = 3'd7;
    #1;
    checkCount++; if (oPhase !== 3'd0) $display("FAIL offset7: got %0d want 0", oPhase); else passCount++;
    iHallOffset = 3'd5;
    #1;
    checkCount++; if (oPhase !== 3'd5) $display("FAIL offset5: got %0d want 5", oPhase); else passCount++;
    iHallOffset = 3'd2;
    #1;
    checkCount++; if (oFault !== 3'b000) $display("FAIL rot_fault: got %b want 000", oFault); else passCount++;
  endtask

  task automatic test_glitch();
    tExp e;
    iHall = 3'd3;
    tick(3);
    iHall = 3'd1;
    tick(20);
    checkCount++; if (oPhase !== 3'd2) $display("FAIL glitch3_phase: got %0d want 2", oPhase); else passCount++;
    checkCount++; if (oPosition !== 16'sd6) $display("FAIL glitch3_pos: got %0d want 6", oPosition); else passCount++;
    checkCount++; if (oFault !== 3'b000) $display("FAIL glitch3_fault: got %b want 000", oFault); else passCount++;
    // A pulse exactly as long as the filter depth is accepted, both ways.
    drive_hall(3'd3, 24'd0);
    tick(4);
    drive_hall(3'd1, 24'd4);
    tick(20);
    void'(sbQ.pop_front());
    e = sbQ.pop_front();
    checkCount++; if (oPhase !== e.phase) $display("FAIL glitch4_phase: got %0d want %0d", oPhase, e.phase); else passCount++;
    checkCount++; if (oPosition !== e.pos) $display("FAIL glitch4_pos: got %0d want %0d", oPosition, e.pos); else passCount++;
    checkCount++; if (oPeriod !== e.period) $display("FAIL glitch4_period: got %0d want %0d", oPeriod, e.period); else passCount++;
    mOut = e.phase;
  endtask

  task automatic test_invalid_skip();
    tExp e;
    logic [2:0] seq [3];
    seq = '{3'd7, 3'd3, 3'd1};
    for (int i = 0; i < 3; i++) begin
      drive_hall(seq[i], 24'd20);
      tick(5);
      if (i == 0) begin
        checkCount++; if (oFault !== 3'b000) $display("FAIL inv_early: got %b want 000", oFault); else passCount++;
      end
      tick(1);
      e = sbQ.pop_front();
      checkCount++; if (oPhase !== e.phase) $display("FAIL inv_phase[%0d]: got %0d want %0d", i, oPhase, e.phase); else passCount++;
      checkCount++; if (oPosition !== e.pos) $display("FAIL inv_pos[%0d]: got %0d want %0d", i, oPosition, e.pos); else passCount++;
      checkCount++; if (oFault !== e.fault) $display("FAIL inv_fault[%0d]: got %b want %b", i, oFault, e.fault); else passCount++;
      if (i == 0) begin
        checkCount++; if (oDriveEnable !== 1'b1) $display("FAIL inv_drive_lag: got %0d want 1", oDriveEnable); else passCount++;
        tick(1);
        checkCount++; if (oDriveEnable !== 1'b0) $display("FAIL inv_drive_off: got %0d want 0", oDriveEnable); else passCount++;
        tick(13);
      end else begin
        tick(14);
      end
      mOut = e.phase;
    end
    iFaultClear = 1'b1; tick(1); iFaultClear = 1'b0; mFault = '0;
    checkCount++; if (oFault !== 3'b000) $display("FAIL clear_fault: got %b want 000", oFault); else passCount++;
    tick(1);
    checkCount++; if (oDriveEnable !== 1'b1) $display("FAIL clear_drive: got %0d want 1", oDriveEnable); else passCount++;
    // Jump 1 -> 6 is a skip.
    drive_hall(3'd6, 24'd0);
    tick(6);
    e = sbQ.pop_front();
    checkCount++; if (oPhase !== e.phase) $display("FAIL skip_phase: got %0d want %0d", oPhase, e.phase); else passCount++;
    checkCount++; if (oPosition !== e.pos) $display("FAIL skip_pos: got %0d want %0d", oPosition, e.pos); else passCount++;
    checkCount++; if (oFault !== 3'b010) $display("FAIL skip_fault: got %b want 010", oFault); else passCount++;
    mOut = e.phase;
    tick(10);
    iFaultClear = 1'b1; tick(1); iFaultClear = 1'b0; mFault = '0;
  endtask

  task automatic test_stall();
    tExp e;
    iStallLimit = 24'd100;
    drive_hall(3'd4, 24'd0);
    tick(6);
    e = sbQ.pop_front();
    checkCount++; if (oPosition !== e.pos) $display("FAIL stall_pos: got %0d want %0d", oPosition, e.pos); else passCount++;
    tick(99);
    checkCount++; if (oFault !== 3'b000) $display("FAIL stall_early: got %b want 000", oFault); else passCount++;
    tick(1);
    checkCount++; if (oFault !== 3'b100) $display("FAIL stall_set: got %b want 100", oFault); else passCount++;
    iFaultClear = 1'b1; tick(1); iFaultClear = 1'b0;
    tick(300);
    checkCount++; if (oFault !== 3'b000) $display("FAIL stall_retrigger: got %b want 000", oFault); else passCount++;
    // Clear coincident with a fresh stall event: the fault wins.
    drive_hall(3'd5, 24'd0);
    tick(6);
    e = sbQ.pop_front();
    mOut = e.phase;
    tick(99);
    checkCount++; if (oFault !== 3'b000) $display("FAIL stall2_early: got %b want 000", oFault); else passCount++;
    iFaultClear = 1'b1; tick(1); iFaultClear = 1'b0;
    checkCount++; if (oFault !== 3'b100) $display("FAIL stall_clear_race: got %b want 100", oFault); else passCount++;
    iFaultClear = 1'b1; tick(1); iFaultClear = 1'b0;
    checkCount++; if (oFault !== 3'b000) $display("FAIL stall_clear: got %b want 000", oFault); else passCount++;
    iStallLimit = 24'd0;
  endtask

  task automatic test_reset_mid();
    tExp e;
    logic [2:0] seq [3];
    seq = '{3'd3, 3'd1, 3'd5};
    iHall = 3'd1;
    tick(2);
    #2 iReset = 1'b1;
    #1;
    checkCount++; if (oPhase !== 3'd0) $display("FAIL rmid_phase: got %0d want 0", oPhase); else passCount++;
    checkCount++; if (oPosition !== 16'sd0) $display("FAIL rmid_pos: got %0d want 0", oPosition); else passCount++;
    checkCount++; if (oPeriod !== 24'd0) $display("FAIL rmid_period: got %0d want 0", oPeriod); else passCount++;
    checkCount++; if (oDriveEnable !== 1'b0) $display("FAIL rmid_drive: got %0d want 0", oDriveEnable); else passCount++;
    tick(2);
    iReset = 1'b0;
    mOut = 3'd0; mPos = '0; mPeriod = '0; mFault = '0; mLoaded = 1'b0;
    drive_hall(3'd1, 24'd0);
    tick(10);
    e = sbQ.pop_front();
    checkCount++; if (oPhase !== e.phase) $display("FAIL rmid_load_phase: got %0d want %0d", oPhase, e.phase); else passCount++;
    checkCount++; if (oPosition !== e.pos) $display("FAIL rmid_load_pos: got %0d want %0d", oPosition, e.pos); else passCount++;
    checkCount++; if (oPeriod !== e.period) $display("FAIL rmid_load_period: got %0d want %0d", oPeriod, e.period); else passCount++;
    checkCount++; if (oDriveEnable !== 1'b1) $display("FAIL rmid_drive_back: got %0d want 1", oDriveEnable); else passCount++;
    for (int i = 0; i < 3; i++) begin
      drive_hall(seq[i], 24'd0);
      tick(6);
      e = sbQ.pop_front();
      checkCount++; if (oPhase !== e.phase) $display("FAIL rmid_phase[%0d]: got %0d want %0d", i, oPhase, e.phase); else passCount++;
      checkCount++; if (oPosition !== e.pos) $display("FAIL rmid_pos[%0d]: got %0d want %0d", i, oPosition, e.pos); else passCount++;
      checkCount++; if (oFault !== e.fault) $display("FAIL rmid_fault[%0d]: got %b want %b", i, oFault, e.fault); else passCount++;
      tick(14);
    end
  endtask

  initial begin
    iReset = 1'b1; iEnable = 1'b1; iMode = 1'b0; iDir = 1'b0; iStop = 1'b0;
    iDiv = 32'd0; iHall = 3'd0; iHallOffset = 3'd0; iStallLimit = 24'd0; iFaultClear = 1'b0;
    mOffset = 3'd0;
    test_reset();
    test_open_loop();
    test_hall_rotation();
    test_glitch();
    test_invalid_skip();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
